// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for a small RV32I subset.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// It produces the datapath strobes combinationally from the current state and
// the instruction fields. A wait counter bounds how long FETCH or MEM may stall
// on mem_ready. Any illegal instruction or stall timeout parks the unit in a
// sticky TRAP state that only rst_n can leave.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   opcode/funct3/      instruction register fields (ignored while in FETCH)
//   funct7_5
//   zero                ALU zero flag, decides a BEQ
//   mem_ready           completion of the current memory request
//   mem_req, mem_we     memory request / write enable
//   ir_we, pc_we,       instruction register write, PC write,
//   pc_src              PC source (0 = pc+4, 1 = branch target)
//   reg_we, wb_sel      register file write, writeback select (1 = memory)
//   alu_src_b           ALU B operand select (1 = immediate)
//   alu_op              ALU control code
//   trap, retire        sticky trap flag, instruction-retired pulse
//   state               current state code
// -----------------------------------------------------------------------------
module mc_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic       reg_we,
   output logic       wb_sel,
   output logic       alu_src_b,
   output logic       trap,
   output logic       retire,
   output logic [3:0] alu_op,
   output logic [2:0] state
);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   logic [2:0] state_q, state_d;
   logic [7:0] wait_q, wait_d;

   logic is_opimm, is_op, is_load, is_store, is_branch;
   logic legal_f3, legal;
   logic rdy, timed_out;
   logic [3:0] alu_exec;

   // Instruction classification and legality.
   always_comb begin
      is_opimm  = (opcode == OPC_OPIMM);
      is_op     = (opcode == OPC_OP);
      is_load   = (opcode == OPC_LOAD);
      is_store  = (opcode == OPC_STORE);
      is_branch = (opcode == OPC_BRANCH);
      legal_f3  = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                  (funct3 == 3'b110) || (funct3 == 3'b010);
      legal     = (is_opimm & legal_f3)
                | (is_op & ((legal_f3 & ~funct7_5) | ((funct3 == 3'b000) & funct7_5)))
                | ((is_load | is_store) & (funct3 == 3'b010))
                | (is_branch & (funct3 == 3'b000));
   end

   // ALU code for the EXEC cycle.
   always_comb begin
      alu_exec = ALU_ADD;
      if (is_load || is_store) begin
         alu_exec = ALU_ADD;
      end else if (is_branch) begin
         alu_exec = ALU_SUB;
      end else begin
         case (funct3)
            3'b000:  alu_exec = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_exec = ALU_AND;
            3'b110:  alu_exec = ALU_OR;
            3'b010:  alu_exec = ALU_SLT;
            default: alu_exec = ALU_ADD;
         endcase
      end
   end

   // Next state and outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; an unassigned path would infer a latch.
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      alu_src_b = 1'b0;
      trap      = 1'b0;
      retire    = 1'b0;
      alu_op    = ALU_ADD;

      // Completion is masked while reset is held so that asserting rst_n
      // cuts off any pc_we/ir_we immediately, even with mem_ready high.
      rdy       = mem_ready & rst_n;
      // Ready on the last allowed cycle wins over the timeout.
      timed_out = (wait_q == TIMEOUT_C) & ~mem_ready;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (rdy) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (timed_out) begin
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: begin
            state_d = legal ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            alu_op    = alu_exec;
            alu_src_b = is_opimm | is_load | is_store;
            if (is_branch) begin
               pc_we   = zero;
               pc_src  = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (is_load || is_store) begin
               state_d = ST_MEM;
            end else if (is_op || is_opimm) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_TRAP;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (rdy) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = is_load ? ST_WB : ST_TRAP;
               end
            end else if (timed_out) begin
               state_d = ST_TRAP;
            end
         end
         ST_WB: begin
            reg_we  = 1'b1;
            wb_sel  = is_load;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_d = ST_TRAP;
         end
      endcase

      // The counter restarts on every state change, so it is zero on entry to
      // FETCH or MEM; it only advances while stalled there.
      if (state_d != state_q) begin
         wait_d = 8'd0;
      end else if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   assign state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         wait_q  <= 8'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples the pre-edge value regardless of statement order.
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Each instruction is expanded by a reference model into its expected per-cycle
// trace (fetch stalls, decode, exec, memory stalls, writeback). The model is
// derived from the instruction's class and memory delays. It is then compared
// cycle by cycle against a packed snapshot of every DUT output.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel;
   logic       alu_src_b, trap, retire;
   logic [3:0] alu_op;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   mc_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
      .alu_src_b(alu_src_b), .trap(trap), .retire(retire),
      .alu_op(alu_op), .state(state)
   );

   always #5 clk = ~clk;

   // Strobe bit positions in the packed snapshot (low 10 bits).
   localparam logic [9:0] S_MREQ  = 10'b10_0000_0000;
   localparam logic [9:0] S_MWE   = 10'b01_0000_0000;
   localparam logic [9:0] S_IRWE  = 10'b00_1000_0000;
   localparam logic [9:0] S_PCWE  = 10'b00_0100_0000;
   localparam logic [9:0] S_PCSRC = 10'b00_0010_0000;
   localparam logic [9:0] S_REGWE = 10'b00_0001_0000;
   localparam logic [9:0] S_WBSEL = 10'b00_0000_1000;
   localparam logic [9:0] S_SRCB  = 10'b00_0000_0100;
   localparam logic [9:0] S_TRAP  = 10'b00_0000_0010;
   localparam logic [9:0] S_RET   = 10'b00_0000_0001;
   localparam logic [9:0] S_NONE  = 10'b00_0000_0000;
   localparam logic [16:0] RST_W  = {3'd0, 4'b0010, S_MREQ};

   localparam int C_OPIMM = 0, C_OP = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_OTHER = 5;

   function automatic logic [16:0] obs();
      return {state, alu_op, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we,
              wb_sel, alu_src_b, trap, retire};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0010011: return C_OPIMM;
         7'b0110011: return C_OP;
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b1100011: return C_BRANCH;
         default:    return C_OTHER;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      bit base_f3;
      base_f3 = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
      case (classify(op))
         C_OPIMM:         return base_f3;
         C_OP:            return (base_f3 && !f7) || (f3 == 3'b000 && f7);
         C_LOAD, C_STORE: return f3 == 3'b010;
         C_BRANCH:        return f3 == 3'b000;
         default:         return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      int c;
      c = classify(op);
      if (c == C_LOAD || c == C_STORE) return 4'b0010;
      if (c == C_BRANCH) return 4'b0110;
      case (f3)
         3'b000:  return (c == C_OP && f7) ? 4'b0110 : 4'b0010;
         3'b111:  return 4'b0000;
         3'b110:  return 4'b0001;
         3'b010:  return 4'b0111;
         default: return 4'b0010;
      endcase
   endfunction

   // One cycle: entered just after a rising edge; drives mem_ready, checks the
   // combinational outputs at the falling edge, leaves just after the next rise.
   task automatic cyc(input logic rdy, input logic [16:0] want, input string tag);
      mem_ready = rdy;
      @(negedge clk);
      check(tag, 32'(obs()), 32'(want));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("rst_now", 32'(obs()), 32'(RST_W));
      @(negedge clk);
      check("rst_hold", 32'(obs()), 32'(RST_W));
      @(posedge clk);
      #1;
      check("rst_edge", 32'(obs()), 32'(RST_W));
      rst_n = 1'b1;
      mem_ready = 1'b0;
   endtask

   // Run one whole instruction against its expected trace.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int fdly, input int mdly);
      int c;
      bool_t: begin end
      c = classify(op);
      // FETCH must ignore the instruction fields, so scramble them meanwhile.
      for (int i = 0; i <= fdly; i++) begin
         opcode   = 7'($urandom);
         funct3   = 3'($urandom);
         funct7_5 = 1'($urandom);
         zero     = 1'($urandom);
         cyc(i == fdly, {3'd0, 4'b0010, (i == fdly) ? (S_MREQ | S_IRWE | S_PCWE) : S_MREQ}, "fetch");
      end
      opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
      cyc(1'($urandom), {3'd1, 4'b0010, S_NONE}, "decode");
      if (!is_legal(op, f3, f7)) begin
         for (int i = 0; i < 3; i++) cyc(1'($urandom), {3'd5, 4'b0010, S_TRAP}, "trap_sticky");
         do_reset();
         return;
      end
      if (c == C_BRANCH) begin
         cyc(1'($urandom), {3'd2, 4'b0110, (z ? S_PCWE : S_NONE) | S_PCSRC | S_RET}, "exec_beq");
         return;
      end
      cyc(1'($urandom), {3'd2, exp_alu(op, f3, f7), (c == C_OP) ? S_NONE : S_SRCB}, "exec");
      if (c == C_LOAD || c == C_STORE) begin
         for (int j = 0; j <= mdly; j++) begin
            cyc(j == mdly, {3'd3, 4'b0010, S_MREQ | ((c == C_STORE) ? S_MWE : S_NONE)
                            | ((j == mdly && c == C_STORE) ? S_RET : S_NONE)}, "mem");
         end
         if (c == C_STORE) return;
      end
      cyc(1'($urandom), {3'd4, 4'b0010, S_REGWE | S_RET | ((c == C_LOAD) ? S_WBSEL : S_NONE)}, "wb");
   endtask

   // Watchdog: the stimulus is cycle-bounded, this only guards a broken clock.
   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Directed instructions.
      run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);   // ADDI, 4 cycles
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // SUB
      run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 1, 0);   // OR
      run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);   // SLT
      run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 2, 0);   // AND
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);   // LW, ready delayed 3
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);   // SW
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // BEQ taken
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);   // BEQ not taken
      run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 15, 0);  // ready on 16th fetch cycle
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 15);  // ready on 16th mem cycle

      // Fetch timeout: 16 stalled cycles then a sticky trap.
      for (int i = 0; i < 16; i++) cyc(1'b0, {3'd0, 4'b0010, S_MREQ}, "fetch_stall");
      for (int i = 0; i < 4; i++) cyc(1'($urandom), {3'd5, 4'b0010, S_TRAP}, "timeout_trap");
      do_reset();

      // Illegal instructions.
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0);

      // Reset mid-wait: must abort at once and restart the wait count.
      for (int i = 0; i < 7; i++) cyc(1'b0, {3'd0, 4'b0010, S_MREQ}, "fetch_prewait");
      #2;
      do_reset();
      run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 15, 0);

      // Randomized instruction stream.
      for (int n = 0; n < 80; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         logic       f7;
         int         k;
         k  = $urandom_range(0, 5);
         f3 = 3'($urandom);
         f7 = 1'($urandom);
         case (k)
            0: op = 7'b0010011;
            1: op = 7'b0110011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            default: op = 7'($urandom);
         endcase
         if (k >= 2 && k <= 3 && $urandom_range(0, 3) != 0) f3 = 3'b010;
         if (k == 4 && $urandom_range(0, 3) != 0) f3 = 3'b000;
         run_instr(op, f3, f7, 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
